// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three buses around the shared memory arbiter:
//     fetch port : if_req, if_addr -> if_rdata, if_valid, if_stall
//     data port  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_valid, d_stall
//     memory     : m_req, m_we, m_addr, m_wdata -> m_rdata, m_ready
//   modport slave  : the arbiter side
//   modport master : the pipeline + memory side (requesters and memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              d_stall;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the IF fetch port and the MEM
//   data port. Data normally wins; a starvation counter forces a fetch grant
//   after STARVE_LIMIT consecutive data grants made while a fetch waited.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     bus (slave) : fetch port, data port and memory port signals
//   Optional: define ARB_PERF_CNT_EN to add if_stall_cnt / d_stall_cnt,
//   32-bit saturating counts of cycles each stall output was high.
//
//   state  | meaning
//   IDLE   | arbitrate; on a grant, latch the memory command
//   BUSY_I | fetch access outstanding, waiting for m_ready
//   BUSY_D | data access outstanding, waiting for m_ready
//   RESP   | one-cycle valid pulse, no arbitration
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] if_stall_cnt,
  output logic [31:0] d_stall_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t     state, state_nxt;
  logic       grant_i, grant_d, done;
  logic [3:0] starve_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // data wins a tie unless the fetch port has waited out its limit
        grant_d = bus.d_req && !(bus.if_req && starve_cnt == LIMIT);
        grant_i = bus.if_req && !grant_d;
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (bus.m_ready) begin
          done      = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_req    <= 1'b0;
      bus.m_we     <= 1'b0;
      bus.m_addr   <= {ADDR_W{1'b0}};
      bus.m_wdata  <= {DATA_W{1'b0}};
      bus.if_rdata <= {DATA_W{1'b0}};
      bus.d_rdata  <= {DATA_W{1'b0}};
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      starve_cnt   <= 4'd0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      if (grant_d) begin
        bus.m_req   <= 1'b1;
        bus.m_we    <= bus.d_we;
        bus.m_addr  <= bus.d_addr;
        bus.m_wdata <= bus.d_wdata;
      end else if (grant_i) begin
        bus.m_req   <= 1'b1;
        bus.m_we    <= 1'b0;
        bus.m_addr  <= bus.if_addr;
        bus.m_wdata <= {DATA_W{1'b0}};
      end
      if (done) begin
        bus.m_req <= 1'b0;
        if (state == BUSY_I) begin
          bus.if_rdata <= bus.m_rdata;
          bus.if_valid <= 1'b1;
        end else begin
          // stores leave the load data register untouched
          if (!bus.m_we) bus.d_rdata <= bus.m_rdata;
          bus.d_valid <= 1'b1;
        end
      end
      if (state == IDLE) begin
        if (grant_i || !bus.if_req)
          starve_cnt <= 4'd0;
        else if (grant_d && starve_cnt != LIMIT)
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign bus.if_stall = bus.if_req & ~bus.if_valid;
  assign bus.d_stall  = bus.d_req  & ~bus.d_valid;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_stall_cnt <= 32'd0;
      d_stall_cnt  <= 32'd0;
    end else begin
      if (bus.if_stall && if_stall_cnt != 32'hFFFF_FFFF) if_stall_cnt <= if_stall_cnt + 32'd1;
      if (bus.d_stall  && d_stall_cnt  != 32'hFFFF_FFFF) d_stall_cnt  <= d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized requests, checked against a
//   transaction-level model: grant order from the arbitration rules, data from
//   a small memory array, valid/stall timing from the memory handshake.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_cnt, d_stall_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .if_stall_cnt (if_stall_cnt),
    .d_stall_cnt  (d_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  int          starve_m;
  int          outstanding;   // 0 none, 1 fetch, 2 data
  int          exp_valid;     // port whose valid is due at the next sample
  int          idle_age;      // -1 transaction in flight, 0 first idle sample, 1 may grant
  int          wait_left;
  bit          delivered;
  int          force_wait = -1;
  bit          mem_hold = 1'b0;
  bit          spurious_en = 1'b0;
  bit          force_late = 1'b0;
  bit          cur_vf, cur_vd, if_done_now, d_done_now;
  logic [31:0] g_addr, g_wdata, exp_if_rdata, exp_d_rdata;
  bit          g_we;
  logic [31:0] if_cnt_m, d_cnt_m;
  int          glog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic raise_if(input logic [31:0] addr);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
  endtask

  task automatic raise_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
  endtask

  task automatic observe();
    bit vf, vd, fi, fd;
    int port;
    vf = (exp_valid == 1);
    vd = (exp_valid == 2);
    exp_valid = 0;
    cur_vf = vf;
    cur_vd = vd;
    if_done_now = 1'b0;
    d_done_now  = 1'b0;
    chk("if_valid", bus.if_valid, vf);
    chk("d_valid", bus.d_valid, vd);
    chk("if_rdata", bus.if_rdata, exp_if_rdata);
    chk("d_rdata", bus.d_rdata, exp_d_rdata);
    chk("if_stall", bus.if_stall, bus.if_req && !vf);
    chk("d_stall", bus.d_stall, bus.d_req && !vd);
`ifdef ARB_PERF_CNT_EN
    chk("if_stall_cnt", if_stall_cnt, if_cnt_m);
    chk("d_stall_cnt", d_stall_cnt, d_cnt_m);
`endif
    if (idle_age == 0) begin
      chk("m_req_after_resp", bus.m_req, 1'b0);
      idle_age = 1;
    end else if (idle_age > 0) begin
      fi = bus.if_req;
      fd = bus.d_req;
      chk("grant_taken", bus.m_req, fi || fd);
      if (bus.m_req === 1'b1 && (fi || fd)) begin
        if (fi && fd) port = (starve_m == LIMIT) ? 1 : 2;
        else          port = fd ? 2 : 1;
        if (port == 1)  starve_m = 0;
        else if (fi)    starve_m = (starve_m < LIMIT) ? starve_m + 1 : LIMIT;
        else            starve_m = 0;
        glog.push_back(port);
        if (port == 1) begin
          g_addr = bus.if_addr; g_we = 1'b0; g_wdata = 32'h0;
        end else begin
          g_addr = bus.d_addr; g_we = bus.d_we; g_wdata = bus.d_wdata;
          chk("m_wdata", bus.m_wdata, g_wdata);
        end
        chk("m_addr", bus.m_addr, g_addr);
        chk("m_we", bus.m_we, g_we);
        outstanding = port;
        idle_age    = -1;
        delivered   = 1'b0;
        wait_left   = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
      end
    end else begin
      if (vf || vd) begin
        chk("m_req_resp", bus.m_req, 1'b0);
      end else begin
        chk("m_req_held", bus.m_req, 1'b1);
        chk("m_addr_held", bus.m_addr, g_addr);
        chk("m_we_held", bus.m_we, g_we);
      end
    end
    if (vf) begin bus.if_req = 1'b0; if_done_now = 1'b1; end
    if (vd) begin bus.d_req  = 1'b0; d_done_now  = 1'b1; end
    if (vf || vd) begin outstanding = 0; idle_age = 0; end
    // memory model
    if (outstanding != 0 && !delivered) begin
      if (mem_hold || wait_left > 0) begin
        if (!mem_hold) wait_left--;
        bus.m_ready = 1'b0;
        bus.m_rdata = $urandom();
      end else begin
        bus.m_ready = 1'b1;
        bus.m_rdata = mem[g_addr[5:2]];
        if (g_we)             mem[g_addr[5:2]] = g_wdata;
        else if (outstanding == 1) exp_if_rdata = mem[g_addr[5:2]];
        else                  exp_d_rdata  = mem[g_addr[5:2]];
        exp_valid = outstanding;
        delivered = 1'b1;
      end
    end else begin
      bus.m_ready = force_late || (spurious_en && $urandom_range(0, 3) == 0);
      bus.m_rdata = $urandom();
      force_late  = 1'b0;
    end
  endtask

  task automatic tick();
    if (bus.if_req && !cur_vf) if_cnt_m++;
    if (bus.d_req && !cur_vd)  d_cnt_m++;
    @(negedge clk);
    observe();
  endtask

  task automatic run_until_quiet(input int max_cycles);
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < max_cycles && !quiet; i++) begin
      tick();
      quiet = !bus.if_req && !bus.d_req && outstanding == 0;
    end
    chk("quiet_timeout", quiet, 1'b1);
  endtask

  task automatic model_reset();
    starve_m = 0; outstanding = 0; exp_valid = 0; delivered = 1'b0;
    cur_vf = 1'b0; cur_vd = 1'b0;
    exp_if_rdata = 32'h0; exp_d_rdata = 32'h0;
    if_cnt_m = 32'h0; d_cnt_m = 32'h0;
  endtask

  initial begin
    logic [31:0] prev_d;
    int          exp_ord [6];
    bit          got;
    exp_ord = '{2, 2, 1, 2, 2, 1};
    for (int i = 0; i < 16; i++) mem[i] = $urandom();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_ready = 1'b0; bus.m_rdata = '0;
    model_reset();
    idle_age = -1;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_m_req", bus.m_req, 1'b0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_if_valid", bus.if_valid, 1'b0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    rst_n = 1'b1;
    idle_age = 1;

    // fetch only, zero-wait memory
    force_wait = 0;
    mem[13] = 32'h2008_0004;
    raise_if(32'd116);
    #1;
    chk("fo_stall_c0", bus.if_stall, 1'b1);
    chk("fo_m_req_c0", bus.m_req, 1'b0);
    tick();
    chk("fo_m_req_c1", bus.m_req, 1'b1);
    chk("fo_stall_c1", bus.if_stall, 1'b1);
    tick();
    chk("fo_valid_c2", bus.if_valid, 1'b1);
    chk("fo_rdata_c2", bus.if_rdata, 32'h2008_0004);
    run_until_quiet(10);

    // simultaneous requests, two wait states
    force_wait = 2;
    glog.delete();
    raise_if(32'd120);
    raise_d(1'b0, 32'h40, 32'h0);
    run_until_quiet(40);
    chk("sim_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("sim_first", glog[0], 2);
      chk("sim_second", glog[1], 1);
    end

    // store leaves d_rdata alone
    force_wait = 1;
    prev_d = exp_d_rdata;
    raise_d(1'b1, 32'h10, 32'hDEAD_BEEF);
    run_until_quiet(20);
    chk("st_d_rdata", bus.d_rdata, prev_d);

    // starvation: both ports re-request continuously
    force_wait = -1;
    glog.delete();
    raise_if(32'h100);
    raise_d(1'b0, 32'h200, 32'h0);
    for (int i = 0; i < 120 && glog.size() < 6; i++) begin
      tick();
      if (!bus.if_req && !if_done_now && glog.size() < 6) raise_if(32'h100 + 32'(i * 4));
      if (!bus.d_req && !d_done_now && glog.size() < 6)   raise_d(1'b0, 32'h200 + 32'(i * 4), 32'h0);
    end
    run_until_quiet(40);
    chk("stv_count", glog.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) if (i < glog.size()) chk("stv_order", glog[i], exp_ord[i]);

    // reset while a data access is outstanding
    mem_hold = 1'b1;
    raise_d(1'b0, 32'h40, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = (outstanding == 2);
    end
    chk("rb_granted", got, 1'b1);
    tick();
    rst_n = 1'b0;
    bus.d_req = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk("rb_m_req", bus.m_req, 1'b0);
    chk("rb_m_we", bus.m_we, 1'b0);
    chk("rb_m_addr", bus.m_addr, 32'h0);
    chk("rb_m_wdata", bus.m_wdata, 32'h0);
    chk("rb_if_rdata", bus.if_rdata, 32'h0);
    chk("rb_d_rdata", bus.d_rdata, 32'h0);
    chk("rb_d_valid", bus.d_valid, 1'b0);
`ifdef ARB_PERF_CNT_EN
    chk("rb_if_cnt", if_stall_cnt, 32'h0);
    chk("rb_d_cnt", d_stall_cnt, 32'h0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_hold = 1'b0;
    idle_age = 1;
    force_late = 1'b1;
    tick();
    tick();
    tick();

    // randomized traffic with spurious m_ready outside BUSY
    spurious_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!bus.if_req && !if_done_now && $urandom_range(0, 2) == 0)
        raise_if($urandom() & 32'hFFFF_FFFC);
      if (!bus.d_req && !d_done_now && $urandom_range(0, 2) == 0)
        raise_d(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom());
    end
    run_until_quiet(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the IF-stage instruction fetch port and the MEM-stage data port.
- Serialises requests over a variable-latency req/ready memory interface.
- Raises per-port stall outputs; the pipeline uses these to gate PC_Write and IF_ID_Write and to hold EXE_MEM.
- The data port normally wins; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch waits before fetch is forced; legal range 1..15

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (program_counter), stable while if_req
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  fetch port waiting
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address (EXE_MEM_Result)
- d_wdata  in  DATA_W  store data (EXE_MEM_Rt)
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle data completion pulse
- d_stall  out  1  data port waiting
- m_req  out  1  memory request
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid when m_ready
- m_ready  in  1  memory completion strobe

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; m_req, m_we, if_valid, d_valid = 0; m_addr, m_wdata, if_rdata, d_rdata = 0; starve counter = 0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE, arbitration:
  - Only d_req high -> grant data.
  - Only if_req high -> grant fetch.
  - Both high -> data wins, unless starve counter == STARVE_LIMIT, in which case fetch wins.
  - No request -> stay in IDLE.
- On a grant, register m_addr, m_we (d_we for data, 0 for fetch) and m_wdata; m_req = 1 from the next cycle. Go to BUSY_D or BUSY_I.
- BUSY_x:
  - m_req, m_we, m_addr and m_wdata are held stable until m_ready is sampled high.
  - On m_ready: m_req <= 0. For a read, the selected rdata register <= m_rdata (d_rdata is untouched on writes). The selected valid <= 1. Go to RESP.
- RESP: exactly one cycle; the valid pulse is high here; no arbitration takes place. The requester must drop or change req at the end of this cycle. Next state IDLE.
- Minimum transaction: 1 grant cycle + ≥1 BUSY cycle + 1 RESP cycle, i.e. 3 cycles with zero-wait memory.
- m_ready is ignored unless in BUSY_x.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while if_req is high.
  - Clears on a fetch grant, or on any IDLE cycle with if_req low.
- Stall outputs are combinational: if_stall = if_req & ~if_valid; d_stall = d_req & ~d_valid.
- A request arriving while the other port is BUSY or in RESP waits; its stall stays high throughout.
- Requests deasserted before a grant are dropped, with no memory access.
- Requests deasserted during BUSY are illegal; the transaction still completes and the valid pulse still occurs.
- Reset mid-transaction: return to reset values immediately; the outstanding memory access is abandoned; a late m_ready after reset is ignored (state is IDLE).

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs if_stall_cnt and d_stall_cnt, 32 bits each.
  - Each increments every cycle its stall output is high and saturates at 0xFFFFFFFF.
  - Both reset to 0 on rst_n.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Fetch only: if_addr=116, memory returns 0x20080004 with 0 wait -> m_req high cycle 1; if_valid pulses cycle 2 with if_rdata=0x20080004; if_stall high cycles 0–1.
- Simultaneous requests: if_addr=120, d_addr=0x40 read with 2 wait -> data granted first; d_valid, then fetch granted in the next IDLE; if_stall high for the full data transaction.
- Store: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> m_we=1, m_addr=0x10, m_wdata=0xDEADBEEF; d_valid pulses; d_rdata unchanged.
- Starvation, STARVE_LIMIT=2, d_req and if_req continuously high -> grant order D, D, I, D, D, I.
- Reset asserted in BUSY_D, with m_ready arriving 1 cycle after release -> all outputs at reset values; no d_valid; the late m_ready is ignored.
- With ARB_PERF_CNT_EN, fetch held off for 5 cycles by a data access -> if_stall_cnt=5 after completion.
